// File: rtl/sd_host_pkg.sv
// rtl/sd_host_pkg.sv - shared types and register bit positions for the SD command issuer
package sd_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_FIRE   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_DONE   = 3'd5
    } issuer_state_t;

    typedef enum logic [1:0] {
        DONE_OK      = 2'b00,
        DONE_TIMEOUT = 2'b01,
        DONE_CRC     = 2'b10,
        DONE_WDOG    = 2'b11
    } done_status_t;

    typedef enum logic [1:0] {
        RESP_NONE = 2'b00,
        RESP_R136 = 2'b01,
        RESP_R48  = 2'b10,
        RESP_R48B = 2'b11
    } resp_type_t;

    localparam int R00EH_IDX_LSB        = 8;
    localparam int R00EH_IDX_CHK_BIT    = 4;
    localparam int R00EH_CRC_CHK_BIT    = 3;
    localparam int R00EH_RESP_LSB       = 0;
    localparam int R024H_NEW_CMD_BIT    = 0;
    localparam int R032H_TIMEOUT_EN_BIT = 0;

    // Reserved fields of the command register stay zero.
    function automatic logic [15:0] pack_r00eh(
        input logic [5:0] index,
        input resp_type_t resp_type,
        input logic       crc_chk,
        input logic       idx_chk
    );
        logic [15:0] w_val;
        w_val                          = '0;
        w_val[R00EH_IDX_LSB +: 6]      = index;
        w_val[R00EH_IDX_CHK_BIT]       = idx_chk;
        w_val[R00EH_CRC_CHK_BIT]       = crc_chk;
        w_val[R00EH_RESP_LSB +: 2]     = resp_type;
        return w_val;
    endfunction

endpackage

// File: rtl/sd_cmd_issuer_if.sv
// rtl/sd_cmd_issuer_if.sv - request and completion handshakes between CPU side and issuer
interface sd_cmd_issuer_if;

    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_index;
    logic [31:0] req_arg;
    logic [1:0]  req_resp_type;
    logic        req_crc_chk;
    logic        req_idx_chk;
    logic        done_valid;
    logic [1:0]  done_status;
    logic        done_ack;

    modport master (
        output req_valid, req_index, req_arg, req_resp_type, req_crc_chk, req_idx_chk, done_ack,
        input  req_ready, done_valid, done_status
    );

    modport slave (
        input  req_valid, req_index, req_arg, req_resp_type, req_crc_chk, req_idx_chk, done_ack,
        output req_ready, done_valid, done_status
    );

endinterface

// File: rtl/sd_wdog_counter.sv
// rtl/sd_wdog_counter.sv - saturating watchdog counter with clear, enable and expiry flag
module sd_wdog_counter #(
    parameter int LIMIT = 65535
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] C_LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] C_SAT  = W'(LIMIT);

    logic [W-1:0] r_count;

    // Holds at LIMIT instead of wrapping so a stuck enable can never re-arm it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != C_SAT)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_expired = (r_count == C_LAST);

endmodule

// File: rtl/sd_cmd_issuer.sv
// rtl/sd_cmd_issuer.sv - sequences one SD command into the host registers and reports its outcome
module sd_cmd_issuer
    import sd_host_pkg::*;
#(
    parameter int WDOG_CYCLES = 65535,
    parameter bit TIMEOUT_EN  = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    sd_cmd_issuer_if.slave     bus,
    input  logic               cmd_complete_in,
    input  logic               cmd_timeout_err_in,
    input  logic               cmd_crc_err_in,
    output logic [31:0]        R008h_CPU,
    output logic [15:0]        R00eh_CPU,
    output logic [31:0]        R024h_CPU,
    output logic [15:0]        R032h_CPU
);

    issuer_state_t r_state;
    issuer_state_t w_next_state;
    done_status_t  r_done_status;
    done_status_t  w_status_next;
    logic          w_status_load;
    logic          w_capture;
    logic          r_settle;
    logic          r_new_cmd;
    logic [31:0]   r_arg;
    logic [15:0]   r_cmd;
    logic          w_wdog_clear;
    logic          w_wdog_enable;
    logic          w_wdog_expired;

    assign w_wdog_clear  = (r_state == ST_FIRE);
    assign w_wdog_enable = (r_state == ST_WAIT);

    sd_wdog_counter #(
        .LIMIT (WDOG_CYCLES)
    ) u_wdog (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_wdog_clear),
        .i_enable  (w_wdog_enable),
        .o_expired (w_wdog_expired)
    );

    always_comb begin
        w_next_state  = r_state;
        w_capture     = 1'b0;
        w_status_load = 1'b0;
        w_status_next = r_done_status;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle) begin
                    w_next_state = ST_FIRE;
                end
            end
            ST_FIRE: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                // Errors outrank completion; completion outranks the watchdog.
                if (cmd_timeout_err_in) begin
                    w_status_load = 1'b1;
                    w_status_next = DONE_TIMEOUT;
                end else if (cmd_crc_err_in) begin
                    w_status_load = 1'b1;
                    w_status_next = DONE_CRC;
                end else if (cmd_complete_in) begin
                    w_status_load = 1'b1;
                    w_status_next = DONE_OK;
                end else if (w_wdog_expired) begin
                    w_status_load = 1'b1;
                    w_status_next = DONE_WDOG;
                end
                if (w_status_load) begin
                    w_next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (bus.done_ack) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_settle      <= 1'b0;
            r_new_cmd     <= 1'b0;
            r_done_status <= DONE_OK;
            r_arg         <= '0;
            r_cmd         <= '0;
        end else begin
            r_state   <= w_next_state;
            r_settle  <= (r_state == ST_SETTLE) ? ~r_settle : 1'b0;
            // New-command bit is registered off next state so it tracks FIRE/WAIT exactly.
            r_new_cmd <= (w_next_state == ST_FIRE) || (w_next_state == ST_WAIT);
            if (w_capture) begin
                r_arg <= bus.req_arg;
                r_cmd <= pack_r00eh(bus.req_index, resp_type_t'(bus.req_resp_type),
                                    bus.req_crc_chk, bus.req_idx_chk);
            end
            if (w_status_load) begin
                r_done_status <= w_status_next;
            end
        end
    end

    always_comb begin
        R024h_CPU                       = '0;
        R024h_CPU[R024H_NEW_CMD_BIT]    = r_new_cmd;
        R032h_CPU                       = '0;
        R032h_CPU[R032H_TIMEOUT_EN_BIT] = TIMEOUT_EN;
    end

    assign R008h_CPU       = r_arg;
    assign R00eh_CPU       = r_cmd;
    assign bus.req_ready   = (r_state == ST_IDLE);
    assign bus.done_valid  = (r_state == ST_DONE);
    assign bus.done_status = r_done_status;

endmodule

// File: tb/tb_sd_cmd_issuer.sv
// tb/tb_sd_cmd_issuer.sv - directed-vector bench for sd_cmd_issuer
module tb_sd_cmd_issuer;

    localparam int WDOG = 16;

    logic        clock;
    logic        reset;
    logic        cmd_complete_in;
    logic        cmd_timeout_err_in;
    logic        cmd_crc_err_in;
    logic [31:0] R008h_CPU;
    logic [15:0] R00eh_CPU;
    logic [31:0] R024h_CPU;
    logic [15:0] R032h_CPU;

    int n_vec  = 0;
    int n_miss = 0;

    sd_cmd_issuer_if bus ();

    sd_cmd_issuer #(
        .WDOG_CYCLES (WDOG),
        .TIMEOUT_EN  (1'b1)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .bus                (bus),
        .cmd_complete_in    (cmd_complete_in),
        .cmd_timeout_err_in (cmd_timeout_err_in),
        .cmd_crc_err_in     (cmd_crc_err_in),
        .R008h_CPU          (R008h_CPU),
        .R00eh_CPU          (R00eh_CPU),
        .R024h_CPU          (R024h_CPU),
        .R032h_CPU          (R032h_CPU)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                        input logic crc, input logic ichk);
        bus.req_index     = idx;
        bus.req_arg       = arg;
        bus.req_resp_type = rt;
        bus.req_crc_chk   = crc;
        bus.req_idx_chk   = ichk;
        bus.req_valid     = 1'b1;
        tick();
        bus.req_valid     = 1'b0;
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        while (!R024h_CPU[0] && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done_valid && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic ack();
        bus.done_ack = 1'b1;
        tick();
        bus.done_ack = 1'b0;
    endtask

    // Status applied on the first WAIT cycle: shortest possible request-to-done path.
    task automatic fast_case(input string tag, input logic to_err, input logic crc_err,
                             input logic cmp, input logic [1:0] exp_st);
        int n;
        int total;
        send(6'd12, 32'h0000_5A5A, 2'b10, 1'b0, 1'b0);
        total = 1;
        wait_rise(n);
        check_vec({tag, "_rise"}, n, 2);
        total += n;
        tick();
        total++;
        cmd_timeout_err_in = to_err;
        cmd_crc_err_in     = crc_err;
        cmd_complete_in    = cmp;
        tick();
        total++;
        cmd_timeout_err_in = 1'b0;
        cmd_crc_err_in     = 1'b0;
        cmd_complete_in    = 1'b0;
        check_vec({tag, "_clr_r024"}, R024h_CPU, 32'h0);
        wait_done(n);
        check_vec({tag, "_done_wait"}, n, 1);
        total += n;
        check_vec({tag, "_latency"}, total, 6);
        check_vec({tag, "_status"}, bus.done_status, exp_st);
        ack();
        check_vec({tag, "_idle_ready"}, bus.req_ready, 1);
    endtask

    initial begin
        int n;
        reset              = 1'b1;
        cmd_complete_in    = 1'b0;
        cmd_timeout_err_in = 1'b0;
        cmd_crc_err_in     = 1'b0;
        bus.req_valid      = 1'b0;
        bus.req_index      = '0;
        bus.req_arg        = '0;
        bus.req_resp_type  = '0;
        bus.req_crc_chk    = 1'b0;
        bus.req_idx_chk    = 1'b0;
        bus.done_ack       = 1'b0;
        tick();
        tick();
        check_vec("rst_req_ready", bus.req_ready, 1);
        check_vec("rst_done_valid", bus.done_valid, 0);
        check_vec("rst_done_status", bus.done_status, 0);
        check_vec("rst_r008", R008h_CPU, 0);
        check_vec("rst_r00e", R00eh_CPU, 0);
        check_vec("rst_r024", R024h_CPU, 0);
        check_vec("rst_r032", R032h_CPU, 16'h0001);
        reset = 1'b0;
        tick();

        // Test 1: CMD8-style request, completion 3 cycles after the new-command bit rises.
        send(6'd8, 32'h0000_01AA, 2'b10, 1'b1, 1'b1);
        check_vec("t1_ready_drop", bus.req_ready, 0);
        check_vec("t1_r00e", R00eh_CPU, 16'h081A);
        check_vec("t1_r008", R008h_CPU, 32'h0000_01AA);
        wait_rise(n);
        check_vec("t1_rise", n, 2);
        tick();
        tick();
        tick();
        cmd_complete_in = 1'b1;
        tick();
        cmd_complete_in = 1'b0;
        check_vec("t1_clear_r024", R024h_CPU, 0);
        check_vec("t1_clear_nodone", bus.done_valid, 0);
        tick();
        check_vec("t1_done_valid", bus.done_valid, 1);
        check_vec("t1_status", bus.done_status, 2'b00);
        check_vec("t1_r032", R032h_CPU, 16'h0001);
        ack();
        check_vec("t1_ack_done_low", bus.done_valid, 0);
        check_vec("t1_ack_ready", bus.req_ready, 1);

        // Test 2 and priority variants, all on the first WAIT cycle.
        fast_case("t2_to_cmp", 1'b1, 1'b0, 1'b1, 2'b01);
        fast_case("t2_crc_cmp", 1'b0, 1'b1, 1'b1, 2'b10);
        fast_case("t2_to_crc", 1'b1, 1'b1, 1'b0, 2'b01);
        fast_case("t2_cmp", 1'b0, 1'b0, 1'b1, 2'b00);

        // Test 3: watchdog, FIRE plus 16 WAIT cycles with the bit high.
        send(6'd2, 32'h0, 2'b01, 1'b0, 1'b0);
        wait_rise(n);
        check_vec("t3_rise", n, 2);
        n = 0;
        while (R024h_CPU[0] && n < 100) begin
            tick();
            n++;
        end
        check_vec("t3_high_cycles", n, WDOG + 1);
        check_vec("t3_clear_nodone", bus.done_valid, 0);
        wait_done(n);
        check_vec("t3_done_wait", n, 1);
        check_vec("t3_status", bus.done_status, 2'b11);
        check_vec("t3_r024", R024h_CPU, 0);
        ack();

        // Test 4: second request held through WAIT and DONE.
        send(6'd17, 32'hDEAD_BEEF, 2'b01, 1'b0, 1'b0);
        check_vec("t4_r00e_a", R00eh_CPU, 16'h1101);
        wait_rise(n);
        bus.req_index     = 6'd55;
        bus.req_arg       = 32'h1234_5678;
        bus.req_resp_type = 2'b11;
        bus.req_crc_chk   = 1'b1;
        bus.req_idx_chk   = 1'b0;
        bus.req_valid     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_vec("t4_wait_ready", bus.req_ready, 0);
        end
        check_vec("t4_r008_held", R008h_CPU, 32'hDEAD_BEEF);
        cmd_complete_in = 1'b1;
        tick();
        cmd_complete_in = 1'b0;
        tick();
        check_vec("t4_done_valid", bus.done_valid, 1);
        for (int i = 0; i < 2; i++) begin
            check_vec("t4_done_ready", bus.req_ready, 0);
            tick();
        end
        check_vec("t4_r00e_held", R00eh_CPU, 16'h1101);
        ack();
        check_vec("t4_idle_ready", bus.req_ready, 1);
        check_vec("t4_r00e_pre", R00eh_CPU, 16'h1101);
        tick();
        bus.req_valid = 1'b0;
        check_vec("t4_accept_ready", bus.req_ready, 0);
        check_vec("t4_r00e_b", R00eh_CPU, 16'h370B);
        check_vec("t4_r008_b", R008h_CPU, 32'h1234_5678);
        wait_rise(n);
        check_vec("t4_rise_b", n, 2);
        tick();
        cmd_complete_in = 1'b1;
        tick();
        cmd_complete_in = 1'b0;
        wait_done(n);
        check_vec("t4_status_b", bus.done_status, 2'b00);
        ack();

        // Test 5: reset asserted in WAIT, checked before any clock edge.
        send(6'd5, 32'hCAFE_0001, 2'b10, 1'b1, 1'b0);
        wait_rise(n);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_vec("t5_r024", R024h_CPU, 0);
        check_vec("t5_done_valid", bus.done_valid, 0);
        check_vec("t5_req_ready", bus.req_ready, 1);
        check_vec("t5_r008", R008h_CPU, 0);
        check_vec("t5_r00e", R00eh_CPU, 0);
        check_vec("t5_r032", R032h_CPU, 16'h0001);
        #2;
        reset = 1'b0;
        tick();
        fast_case("t5_post", 1'b0, 1'b0, 1'b1, 2'b00);

        // Test 6: DONE held 10 cycles while status inputs toggle.
        send(6'd9, 32'h0000_0001, 2'b01, 1'b0, 1'b0);
        wait_rise(n);
        tick();
        cmd_complete_in = 1'b1;
        tick();
        cmd_complete_in = 1'b0;
        tick();
        check_vec("t6_done_valid", bus.done_valid, 1);
        for (int i = 0; i < 10; i++) begin
            cmd_complete_in    = (i % 2 == 0);
            cmd_timeout_err_in = (i % 2 == 1);
            cmd_crc_err_in     = (i % 3 == 0);
            tick();
            check_vec("t6_hold_valid", bus.done_valid, 1);
            check_vec("t6_hold_status", bus.done_status, 2'b00);
            check_vec("t6_hold_r024", R024h_CPU, 0);
        end
        cmd_complete_in    = 1'b0;
        cmd_timeout_err_in = 1'b0;
        cmd_crc_err_in     = 1'b0;
        ack();
        check_vec("t6_ack_ready", bus.req_ready, 1);
        check_vec("t6_ack_valid", bus.done_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sd_cmd_issuer.md
Name: sd_cmd_issuer

Overview:
CPU-side command sequencer that sits directly upstream of the SD host top level and drives its register-write inputs.
- Accepts one command request at a time over a valid/ready handshake.
- Loads the argument and command registers, pulses the new-command bit, and waits for command-complete, an error, or a watchdog expiry.
- Returns a status code over a second valid/ack handshake.

Parameters:
WDOG_CYCLES, 65535, clock cycles allowed in WAIT before a watchdog abort; width of counter = clog2(WDOG_CYCLES+1)
TIMEOUT_EN, 1, value driven on R032h_CPU[0] (CMD-line timeout enable)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  command request present
req_ready  out  1  issuer can accept a request (IDLE only)
req_index  in  6  command index
req_arg  in  32  command argument
req_resp_type  in  2  response type select (00 none, 01 R136, 10 R48, 11 R48b)
req_crc_chk  in  1  command CRC check enable
req_idx_chk  in  1  command index check enable
cmd_complete_in  in  1  command-complete status (R030h bit 0)
cmd_timeout_err_in  in  1  command timeout error status
cmd_crc_err_in  in  1  command CRC error status
R008h_CPU  out  32  argument register write data
R00eh_CPU  out  16  command register write data
R024h_CPU  out  32  present-state write data; bit 0 is new-command / CMD inhibit
R032h_CPU  out  16  error register write data
done_valid  out  1  completion status valid
done_status  out  2  00 OK, 01 timeout error, 10 CRC error, 11 watchdog
done_ack  in  1  consumer accepts status

Behaviour:
Reset values:
- state IDLE; req_ready=1; done_valid=0; done_status=00.
- R008h_CPU=0; R00eh_CPU=0; R024h_CPU=0; R032h_CPU={15'b0,TIMEOUT_EN}; watchdog counter=0.

R00eh_CPU packing:
- [13:8]=index, [7:6]=00, [5]=0, [4]=idx_chk, [3]=crc_chk, [2]=0, [1:0]=resp_type.

R032h_CPU:
- Constant {15'b0,TIMEOUT_EN} in all states.

States:
- IDLE: req_ready=1. On req_valid&&req_ready, capture all req_* fields into R008h_CPU/R00eh_CPU and go to SETTLE. req_ready drops on the next cycle.
- SETTLE: hold for 2 cycles, which covers the one-cycle register stage in the host, then go to FIRE.
- FIRE: set R024h_CPU[0]=1, clear the watchdog counter, go to WAIT.
- WAIT: keep R024h_CPU[0]=1 and increment the watchdog each cycle. Exit conditions, evaluated in priority order:
  1. cmd_timeout_err_in → status 01.
  2. cmd_crc_err_in → status 10.
  3. cmd_complete_in → status 00.
  4. counter==WDOG_CYCLES-1 → status 11.
  - Whichever condition fires, go to CLEAR.
  - Errors win over a simultaneous complete; complete in the same cycle as watchdog expiry gives 00.
- CLEAR: drive R024h_CPU[0]=0 for one cycle, then go to DONE.
- DONE: done_valid=1, done_status held stable. On done_ack, go to IDLE with done_valid=0 on the next cycle.
  - req_valid is ignored in DONE.
  - A new request can be accepted at the earliest on the cycle after IDLE is re-entered.

General rules:
- Status inputs are sampled only in WAIT; pulses arriving in other states are ignored.
- Watchdog counter saturates; it never wraps.
- Reset asserted mid-operation: every output returns to its reset value asynchronously. R024h_CPU[0] drops immediately, so no command is left pending.
- Request fields are not re-sampled after capture; changing req_* while busy has no effect.
- Minimum request-to-done latency is 6 cycles, with complete arriving on the first WAIT cycle: accept, SETTLE×2, FIRE, WAIT, CLEAR, then done_valid.

Decomposition:
Shared package sd_host_pkg holds:
- state enum (IDLE, SETTLE, FIRE, WAIT, CLEAR, DONE);
- done_status codes;
- response-type codes;
- R00eh/R024h/R032h bit-position constants.

The watchdog is a natural sub-module, sd_wdog_counter: clear, enable, saturating, and an expired flag.

Test Plan:
1. req index=8, arg=0x000001AA, type=10, crc/idx chk=1; cmd_complete_in pulse 3 cycles after R024h_CPU[0] rises → R00eh_CPU=0x081A, R008h_CPU=0x000001AA, done_status=00, R024h_CPU[0] back to 0 before done_valid.
2. cmd_timeout_err_in and cmd_complete_in asserted in the same WAIT cycle → done_status=01.
3. WDOG_CYCLES=16, no status inputs → done_status=11 exactly 16 cycles after FIRE, R024h_CPU[0] cleared.
4. Second req_valid held during WAIT and DONE → req_ready=0 throughout; accepted one cycle after done_ack, with new fields captured.
5. reset asserted during WAIT → R024h_CPU=0, done_valid=0, req_ready=1 immediately; the next request completes normally.
6. done_ack withheld for 10 cycles → done_valid and done_status stable for all 10 cycles; cmd_complete_in pulses in DONE are ignored.
